// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg
//   Shared widths, FSM state type and the byte-address to SRAM-word mapping
//   used by the 16-bit asynchronous SRAM controller.
package sram_controller_pkg;

    localparam int WORD        = 32;  // pipeline data/address width
    localparam int SRAM_DATA   = 16;  // SRAM data bus width
    localparam int SRAM_ADDR_W = 18;  // SRAM half-word address width
    localparam int SRAM_WORD_W = 17;  // 32-bit word index inside the SRAM

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Out-of-range addresses wrap modulo 2^17 words; no error is raised.
    function automatic logic [SRAM_WORD_W-1:0] word_index(
        input logic [WORD-1:0] address,
        input logic [WORD-1:0] base
    );
        return SRAM_WORD_W'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller
//   Sequences a 16-bit asynchronous SRAM for the pipeline's memory stage.
//   Each 32-bit load/store becomes two half-word accesses (LOW then HIGH),
//   each held on the pins for WAIT_CYCLES cycles, followed by a one-cycle
//   DONE state. `ready` stays low while a request is pending and unfinished.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   rd_en, wr_en      : load / store request (both high -> store)
//   address           : byte address; ADDR_BASE maps to SRAM word 0
//   write_data        : store data
//   read_data         : load result, held until the next load overwrites it
//   ready             : low while a request is outstanding
//   SRAM_DQ           : bidirectional SRAM data bus
//   SRAM_ADDR         : SRAM half-word address
//   SRAM_*_N          : active-low SRAM strobes (registered)
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned      WAIT_CYCLES = 5,
    parameter logic [WORD-1:0]  ADDR_BASE   = 32'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [WORD-1:0]        address,
    input  logic [WORD-1:0]        write_data,
    output logic [WORD-1:0]        read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   is_write, is_write_next;
    logic [SRAM_WORD_W-1:0] word, word_next;
    logic [WORD-1:0]        wdata, wdata_next;
    logic                   accept;
    logic                   phase_last;

    // Registered pin state and its next value
    logic                   select_n, select_n_d;   // CE/UB/LB share one flop
    logic                   oe_n_d, we_n_d;
    logic                   dq_oe, dq_oe_d;
    logic [SRAM_DATA-1:0]   dq_out, dq_out_d;
    logic [SRAM_ADDR_W-1:0] addr_d;

    assign accept     = (state == S_IDLE) && (rd_en || wr_en);
    assign phase_last = (cnt == LAST);

    // Request capture; the next-value form lets the pin logic see the
    // request on the same edge that enters LOW.
    assign is_write_next = accept ? wr_en : is_write;
    assign word_next     = accept ? word_index(address, ADDR_BASE) : word;
    assign wdata_next    = accept ? write_data : wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic with the inlined phase counter
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            S_IDLE: begin
                if (rd_en || wr_en) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end
            end
            S_LOW: begin
                if (phase_last) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_last) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DONE: state_next = S_IDLE;
        endcase
    end

    // Pin values are decoded from the *next* state so that the registered
    // pins line up with the cycles that state occupies.
    always_comb begin
        select_n_d = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        dq_oe_d    = 1'b0;
        dq_out_d   = dq_out;
        addr_d     = SRAM_ADDR;
        if (state_next == S_LOW || state_next == S_HIGH) begin
            select_n_d = 1'b0;
            addr_d     = {word_next, state_next == S_HIGH};
            if (is_write_next) begin
                // WE_N released on the last phase cycle for data hold
                we_n_d   = (cnt_next == LAST);
                dq_oe_d  = 1'b1;
                dq_out_d = (state_next == S_HIGH) ? wdata_next[31:16]
                                                  : wdata_next[15:0];
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_write <= 1'b0;
            word     <= '0;
            wdata    <= '0;
        end else begin
            is_write <= is_write_next;
            word     <= word_next;
            wdata    <= wdata_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SRAM_ADDR <= '0;
            select_n  <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            SRAM_ADDR <= addr_d;
            select_n  <= select_n_d;
            SRAM_OE_N <= oe_n_d;
            SRAM_WE_N <= we_n_d;
            dq_oe     <= dq_oe_d;
            dq_out    <= dq_out_d;
        end
    end

    // Read capture on the last cycle of each phase
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (!is_write && phase_last) begin
            if (state == S_LOW)
                read_data[15:0] <= SRAM_DQ;
            else if (state == S_HIGH)
                read_data[31:16] <= SRAM_DQ;
        end
    end

    assign SRAM_CE_N = select_n;
    assign SRAM_UB_N = select_n;
    assign SRAM_LB_N = select_n;
    assign SRAM_DQ   = dq_oe ? dq_out : 'z;

    assign ready = ~(rd_en | wr_en) | (state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Directed and randomized checks of sram_controller (W=5) against a
//   word-level reference memory and the cycle timing of an access.
module tb_sram_controller;

    localparam int W    = 5;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram_controller #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural SRAM: 256K x 16, async read, write on rising WE_N using
    // the pin values held during the preceding cycle.
    logic [15:0] mem [0:262143];
    logic        st_ce_n = 1'b1;
    logic [17:0] st_addr = '0;
    logic [15:0] st_dq = '0;
    initial for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(negedge clk) begin
        st_ce_n = sram_ce_n;
        st_addr = sram_addr;
        st_dq   = sram_dq;
    end
    always @(posedge sram_we_n) if (!st_ce_n) mem[st_addr] = st_dq;

    // Reference: 32-bit words indexed by wrapped word number
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_read = '0;
    int          errors = 0;
    int          checks = 0;
    int          done_cyc = 0;

    function automatic int unsigned ref_word(input logic [31:0] a);
        return ((a - BASE) >> 2) % 131072;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    // Returns just after the edge that ends DONE with requests dropped.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input bit hold);
        int unsigned w;
        bit          is_wr;
        bit          in_phase;
        logic [5:0]  exp_pins;
        logic [31:0] exp_rd;
        w     = ref_word(a);
        is_wr = wr;
        if (is_wr) begin
            exp_rd = last_read;
        end else begin
            exp_rd    = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            last_read = exp_rd;
        end
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int n = 0; n <= 2 * W + 1; n++) begin
            @(negedge clk);
            in_phase = (n >= 1) && (n <= 2 * W);
            exp_pins[5] = (n == 0) ? 1'b0 : (hold ? (n == 2 * W + 1) : 1'b1);
            exp_pins[4] = !in_phase;
            exp_pins[3] = !in_phase;
            exp_pins[2] = !in_phase;
            exp_pins[1] = !(in_phase && !is_wr);
            exp_pins[0] = !(in_phase && is_wr && n != W && n != 2 * W);
            check("ready/ce/ub/lb/oe/we",
                  {26'h0, ready, sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n},
                  {26'h0, exp_pins});
            if (in_phase) begin
                check("sram_addr", {14'h0, sram_addr}, w * 2 + ((n > W) ? 1 : 0));
                if (is_wr)
                    check("dq_write", {16'h0, sram_dq}, {16'h0, (n > W) ? d[31:16] : d[15:0]});
            end
            if (n == 2 * W + 1) begin
                check("read_data", read_data, exp_rd);
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            if (n == 0 && !hold) begin
                rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        if (is_wr) ref_mem[w] = d;
    endtask

    int          start_cyc;
    int          first_done;
    int unsigned op;
    logic [31:0] ra;
    bit          rhold;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pins", {26'h0, ready, sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n},
              32'h3f);
        check("reset_read_data", read_data, 32'h0);
        check("reset_addr", {14'h0, sram_addr}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write, then read back
        run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b1);
        check("mem0", {16'h0, mem[0]}, 32'hBEEF);
        check("mem1", {16'h0, mem[1]}, 32'hDEAD);
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);

        // Address mapping
        run_access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b1);
        check("mem2", {16'h0, mem[2]}, 32'h5678);
        check("mem3", {16'h0, mem[3]}, 32'h1234);

        // Simultaneous read+write behaves as a write
        run_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b1);
        check("mem4", {16'h0, mem[4]}, 32'hF00D);
        check("mem5", {16'h0, mem[5]}, 32'hCAFE);
        check("rd_unchanged", read_data, 32'hDEADBEEF);

        // Reset during cycle 3 of a write
        wr_en = 1'b1; address = 32'd1424; write_data = 32'h55AA33CC;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("rst_mid_pins", {26'h0, ready, sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n},
              32'h3f);
        check("rst_mid_read_data", read_data, 32'h0);
        check("rst_mid_addr", {14'h0, sram_addr}, 32'h0);
        check("rst_mid_dq_release", {31'h0, dut.dq_oe}, 32'h0);
        last_read = 32'h0;
        @(posedge clk); #1;
        start_cyc = cyc;
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
        check("post_rst_latency", done_cyc - start_cyc, 32'd11);

        // Back-to-back read then write
        start_cyc = cyc;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
        first_done = done_cyc;
        run_access(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 1'b1);
        check("b2b_first_done", first_done - start_cyc, 32'd11);
        check("b2b_second_done", done_cyc - start_cyc, 32'd23);

        // Randomized traffic, including wrapped/aliased addresses and
        // requests withdrawn after cycle 0
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            case ($urandom_range(0, 5))
                0:       ra = BASE - 4;                       // wraps to the top word
                1:       ra = BASE + 4 * 131072 + 4 * $urandom_range(0, 3); // aliases low words
                default: ra = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            endcase
            rhold = ($urandom_range(0, 3) != 0);
            run_access(op != 1, op != 0, ra, $urandom, rhold);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
